// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller for the decodec stage.
// It holds the PC and fetches one word per instruction over a request/acknowledge
// handshake. It presents the word for an EXEC cycle, then picks the next PC from
// the decoder's jump and branch requests.
module fetch_sequencer #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 16,
    parameter int BR_W     = 6,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              halt_i,
    input  logic              stall_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [DATA_W-1:0] imem_data_i,
    input  logic              imem_ack_i,
    output logic [DATA_W-1:0] instr_o,
    output logic              instr_valid_o,
    input  logic              jmp_enable_i,
    input  logic [ADDR_W-1:0] jmp_dir_i,
    input  logic              branch_enable_i,
    input  logic [BR_W-1:0]   branch_dir_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              busy_o,
    output logic              fetch_err_o
);

    localparam int                CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] RESET_PC_L = ADDR_W'(RESET_PC);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_HALT  = 3'd3,
        S_ERROR = 3'd4
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   next_pc_d;
    logic [DATA_W-1:0]   instr_q;
    logic [CNT_W-1:0]    wait_cnt_q;
    logic                imem_req_q;
    logic                instr_valid_q;
    logic                busy_q;
    logic                fetch_err_q;

    // Two's-complement sign extension of the branch offset to PC width.
    function automatic logic [ADDR_W-1:0] sext_branch(input logic [BR_W-1:0] off);
        return {{(ADDR_W - BR_W){off[BR_W-1]}}, off};
    endfunction

    // Next-PC selection: absolute jump beats relative branch beats sequential; wraps modulo 2^ADDR_W.
    always_comb begin
        next_pc_d = pc_q + {{(ADDR_W - 1){1'b0}}, 1'b1};
        if (jmp_enable_i) begin
            next_pc_d = jmp_dir_i;
        end else if (branch_enable_i) begin
            next_pc_d = pc_q + sext_branch(branch_dir_i);
        end else begin
            next_pc_d = pc_q + {{(ADDR_W - 1){1'b0}}, 1'b1};
        end
    end

    // Fetch FSM with all outputs registered alongside the state so they track it cycle-exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC_L;
            instr_q       <= {DATA_W{1'b0}};
            wait_cnt_q    <= {CNT_W{1'b0}};
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start_i) begin
                        state_q    <= S_FETCH;
                        imem_req_q <= 1'b1;
                        busy_q     <= 1'b1;
                        wait_cnt_q <= {CNT_W{1'b0}};
                    end else begin
                        state_q <= state_q;
                    end
                end
                S_FETCH: begin
                    if (imem_ack_i) begin
                        state_q       <= S_EXEC;
                        instr_q       <= imem_data_i;
                        wait_cnt_q    <= {CNT_W{1'b0}};
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        // Memory never answered: latch the error, only reset recovers.
                        state_q     <= S_ERROR;
                        wait_cnt_q  <= {CNT_W{1'b0}};
                        imem_req_q  <= 1'b0;
                        busy_q      <= 1'b0;
                        fetch_err_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
                    end
                end
                S_EXEC: begin
                    if (stall_i) begin
                        state_q <= S_EXEC;
                    end else if (halt_i) begin
                        state_q       <= S_HALT;
                        instr_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                    end else begin
                        state_q       <= S_FETCH;
                        pc_q          <= next_pc_d;
                        instr_valid_q <= 1'b0;
                        imem_req_q    <= 1'b1;
                    end
                end
                S_ERROR: begin
                    state_q     <= S_ERROR;
                    fetch_err_q <= 1'b1;
                end
                default: begin
                    state_q       <= S_IDLE;
                    wait_cnt_q    <= {CNT_W{1'b0}};
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                    fetch_err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o    = imem_req_q;
    assign imem_addr_o   = pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = instr_valid_q;
    assign pc_o          = pc_q;
    assign busy_o        = busy_q;
    assign fetch_err_o   = fetch_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random traffic.
// A cycle-level behavioural reference model computes every expected output.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0, halt_i = 1'b0, stall_i = 1'b0;
    logic        imem_req_o;
    logic [9:0]  imem_addr_o;
    logic [15:0] imem_data_i = 16'h0000;
    logic        imem_ack_i = 1'b0;
    logic [15:0] instr_o;
    logic        instr_valid_o;
    logic        jmp_enable_i = 1'b0;
    logic [9:0]  jmp_dir_i = 10'd0;
    logic        branch_enable_i = 1'b0;
    logic [5:0]  branch_dir_i = 6'd0;
    logic [9:0]  pc_o;
    logic        busy_o, fetch_err_o;

    int checks = 0;
    int errors = 0;

    typedef enum {M_IDLE, M_FETCH, M_EXEC, M_HALT, M_ERR} mode_t;
    mode_t m_mode;
    int    m_pc, m_instr, m_wait;

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .halt_i(halt_i), .stall_i(stall_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
        .imem_ack_i(imem_ack_i), .instr_o(instr_o), .instr_valid_o(instr_valid_o),
        .jmp_enable_i(jmp_enable_i), .jmp_dir_i(jmp_dir_i), .branch_enable_i(branch_enable_i),
        .branch_dir_i(branch_dir_i), .pc_o(pc_o), .busy_o(busy_o), .fetch_err_o(fetch_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Spec-level next-PC rule with plain integer arithmetic modulo 1024.
    function automatic int calc_next_pc(int pc, bit j, int jd, bit b, int bd);
        int off;
        if (j) return jd;
        if (b) begin
            off = (bd >= 32) ? bd - 64 : bd;
            return (((pc + off) % 1024) + 1024) % 1024;
        end
        return (pc + 1) % 1024;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_pc = 0; m_instr = 0; m_wait = 0;
    endtask

    task automatic model_edge();
        case (m_mode)
            M_IDLE, M_HALT: if (start_i) begin m_mode = M_FETCH; m_wait = 0; end
            M_FETCH: begin
                if (imem_ack_i) begin
                    m_instr = int'(imem_data_i); m_mode = M_EXEC; m_wait = 0;
                end else begin
                    m_wait++;
                    if (m_wait >= 15) m_mode = M_ERR;
                end
            end
            M_EXEC: if (!stall_i) begin
                if (halt_i) m_mode = M_HALT;
                else begin
                    m_pc = calc_next_pc(m_pc, jmp_enable_i, int'(jmp_dir_i),
                                        branch_enable_i, int'(branch_dir_i));
                    m_mode = M_FETCH;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_all();
        chk("imemReq",    32'(imem_req_o),    32'(m_mode == M_FETCH));
        chk("imemAddr",   32'(imem_addr_o),   32'(m_pc));
        chk("pc",         32'(pc_o),          32'(m_pc));
        chk("instr",      32'(instr_o),       32'(m_instr));
        chk("instrValid", 32'(instr_valid_o), 32'(m_mode == M_EXEC));
        chk("busy",       32'(busy_o),        32'(m_mode == M_FETCH || m_mode == M_EXEC));
        chk("fetchErr",   32'(fetch_err_o),   32'(m_mode == M_ERR));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        rst_n = 1'b1;
    endtask

    // One instruction from FETCH: ack with random data, then leave EXEC with given jmp/branch.
    task automatic run_instr(input bit j, input logic [9:0] jd, input bit b, input logic [5:0] bd);
        imem_ack_i = 1'b1; imem_data_i = 16'($urandom);
        tick();
        imem_ack_i = 1'b0;
        jmp_enable_i = j; jmp_dir_i = jd; branch_enable_i = b; branch_dir_i = bd;
        tick();
        jmp_enable_i = 1'b0; branch_enable_i = 1'b0;
    endtask

    initial begin
        // 1. reset and start
        @(posedge clk); #1;
        do_reset();
        chk("rst_pc", 32'(pc_o), 32'd0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("start_req", 32'(imem_req_o), 32'd1);
        chk("start_addr", 32'(imem_addr_o), 32'd0);

        // 2. ack in first FETCH cycle
        imem_ack_i = 1'b1; imem_data_i = 16'h0280;
        tick();
        imem_ack_i = 1'b0;
        chk("exec_valid", 32'(instr_valid_o), 32'd1);
        chk("exec_instr", 32'(instr_o), 32'h0280);
        tick();
        chk("valid_1cyc", 32'(instr_valid_o), 32'd0);
        chk("seq_addr", 32'(imem_addr_o), 32'd1);

        // 3. branch back and jump priority
        for (int k = 0; k < 4; k++) run_instr(1'b0, 10'd0, 1'b0, 6'd0);
        chk("pc5", 32'(imem_addr_o), 32'd5);
        run_instr(1'b0, 10'd0, 1'b1, 6'b111110);
        chk("branch_neg2", 32'(imem_addr_o), 32'd3);
        run_instr(1'b1, 10'd5, 1'b0, 6'd0);
        run_instr(1'b1, 10'h200, 1'b1, 6'b000011);
        chk("jmp_prio", 32'(imem_addr_o), 32'h200);

        // 4. wraparound both ways
        run_instr(1'b1, 10'h3FF, 1'b0, 6'd0);
        run_instr(1'b0, 10'd0, 1'b0, 6'd0);
        chk("wrap_up", 32'(imem_addr_o), 32'd0);
        run_instr(1'b0, 10'd0, 1'b1, 6'b111111);
        chk("wrap_down", 32'(imem_addr_o), 32'h3FF);

        // 6a. stall holds EXEC, halt then resume
        imem_ack_i = 1'b1; imem_data_i = 16'hBEEF;
        tick();
        imem_ack_i = 1'b0; imem_data_i = 16'h1234; stall_i = 1'b1; jmp_enable_i = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("stall_valid", 32'(instr_valid_o), 32'd1);
        chk("stall_instr", 32'(instr_o), 32'hBEEF);
        stall_i = 1'b0; jmp_enable_i = 1'b0; halt_i = 1'b1;
        tick();
        halt_i = 1'b0;
        chk("halt_busy", 32'(busy_o), 32'd0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("resume_addr", 32'(imem_addr_o), 32'h3FF);

        // 5. fetch timeout
        for (int k = 0; k < 14; k++) tick();
        chk("pre_timeout_req", 32'(imem_req_o), 32'd1);
        tick();
        chk("timeout_err", 32'(fetch_err_o), 32'd1);
        chk("timeout_req", 32'(imem_req_o), 32'd0);
        start_i = 1'b1; imem_ack_i = 1'b1;
        tick(); tick();
        start_i = 1'b0; imem_ack_i = 1'b0;
        chk("err_sticky", 32'(fetch_err_o), 32'd1);
        do_reset();
        chk("err_cleared", 32'(fetch_err_o), 32'd0);

        // 6b. reset mid-FETCH drops the request asynchronously
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_req_drop", 32'(imem_req_o), 32'd0);
        model_reset();
        rst_n = 1'b1;
        imem_ack_i = 1'b1;
        tick();
        imem_ack_i = 1'b0;

        // random traffic
        for (int i = 0; i < 600; i++) begin
            start_i         = ($urandom_range(0, 2) == 0);
            halt_i          = ($urandom_range(0, 5) == 0);
            stall_i         = ($urandom_range(0, 3) == 0);
            imem_ack_i      = ($urandom_range(0, 4) < 3);
            imem_data_i     = 16'($urandom);
            jmp_enable_i    = ($urandom_range(0, 3) == 0);
            jmp_dir_i       = 10'($urandom);
            branch_enable_i = ($urandom_range(0, 1) == 0);
            branch_dir_i    = 6'($urandom);
            if (i % 100 == 99) do_reset();
            else tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
